// File: rtl/spi_reg_bank.sv
// SPI command decoder and byte-wide register bank sitting behind spi_slave.
// Build option: define SPI_REG_AUTOINC_EN for burst access (pointer auto-increment).
module spi_reg_bank #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  STATUS_ID = 8'hA5,
  parameter logic [7:0]  ERR_BYTE  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ss,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                ss_meta;
  logic                ss_sync;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_nxt;
  logic [ADDR_W-1:0]   ptr_step;
  logic [ADDR_W-1:0]   cmd_ptr;
  logic [6:0]          cmd_hi;
  logic                cmd_bad;
  logic                frame_end;
  logic [7:0]          tx_nxt;
  logic                wr_en;
  logic [7:0]          regs [DEPTH];

  // Slave-select crosses in from the pad; idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_meta <= 1'b1;
      ss_sync <= 1'b1;
    end else begin
      ss_meta <= ss;
      ss_sync <= ss_meta;
    end
  end

  assign busy      = ~ss_sync;
  assign frame_end = (state != IDLE) && ss_sync;
  assign cmd_ptr   = rx_byte[ADDR_W-1:0];
  assign cmd_hi    = rx_byte[6:0] >> ADDR_W;
  assign cmd_bad   = |cmd_hi;

`ifdef SPI_REG_AUTOINC_EN
  assign ptr_step = ptr + ADDR_W'(1);
`else
  assign ptr_step = ptr;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; frame end overrides so a final byte is still consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!ss_sync) begin
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (rx_valid) begin
          if (cmd_bad) begin
            state_nxt = ERR;
          end else if (rx_byte[7]) begin
            state_nxt = READ;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE, READ, ERR: begin
        state_nxt = state;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (frame_end) begin
      state_nxt = IDLE;
    end
  end

  // Datapath next values: pointer, transmit byte and write enable
  always_comb begin
    ptr_nxt = ptr;
    tx_nxt  = tx_byte;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_sync) begin
          tx_nxt = STATUS_ID;
        end
      end
      CMD: begin
        if (rx_valid) begin
          ptr_nxt = cmd_ptr;
          if (cmd_bad) begin
            tx_nxt = ERR_BYTE;
          end else if (rx_byte[7]) begin
            tx_nxt = regs[cmd_ptr];
          end else begin
            tx_nxt = rx_byte;
          end
        end
      end
      WRITE: begin
        if (rx_valid) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr_step;
          tx_nxt  = rx_byte;
        end
      end
      READ: begin
        if (rx_valid) begin
          ptr_nxt = ptr_step;
          tx_nxt  = regs[ptr_step];
        end
      end
      ERR: begin
        if (rx_valid) begin
          tx_nxt = ERR_BYTE;
        end
      end
      default: begin
        tx_nxt = STATUS_ID;
      end
    endcase
    if (frame_end) begin
      tx_nxt = STATUS_ID;
    end
  end

  // Datapath registers and write-commit reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      tx_byte   <= STATUS_ID;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      ptr       <= ptr_nxt;
      tx_byte   <= tx_nxt;
      wr_strobe <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  // Register file; contents are cleared by reset as well
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

  // Local read port: one-cycle latency, sees SPI writes one cycle after commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loc_rdata <= '0;
    end else begin
      loc_rdata <= regs[loc_addr];
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: frame-level reference model feeds expected queues.
module tb_spi_reg_bank;

`ifdef SPI_REG_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ss = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_byte;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] loc_addr = 4'h0;
  logic [7:0] loc_rdata;
  logic       busy;

  spi_reg_bank #(.ADDR_W(4), .STATUS_ID(8'hA5), .ERR_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  logic [7:0]  loc_q[$];
  logic [7:0]  fb[$];

  // Reference model state
  logic [7:0] mregs [16];
  int         m_ptr;
  bit         m_err;
  bit         m_rd;

  logic loc_req  = 1'b0;
  logic rxv_seen = 1'b0;
  logic loc_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rxv_seen <= rx_valid && !reset;
    loc_seen <= loc_req && !reset;
  end

  // Monitor: pops an expectation whenever the DUT presents a response
  always @(negedge clk) begin
    if (!reset) begin
      if (rxv_seen) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
      end
      if (wr_strobe) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {wr_addr, wr_data}, 32'hFFFF_FFFF);
        else chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
      end
      if (loc_seen) begin
        if (loc_q.size() == 0) chk("loc_unexpected", 32'd1, 32'd0);
        else chk("loc_rdata", 32'(loc_rdata), 32'(loc_q.pop_front()));
      end
    end
  end

  // Model one received byte of a frame; returns the expected tx byte
  function automatic logic [7:0] model_byte(input bit first, input logic [7:0] b);
    if (first) begin
      m_ptr = int'(b[3:0]);
      m_err = (b[6:4] != 3'b000);
      m_rd  = b[7];
      if (m_err) return 8'hFF;
      if (m_rd) return mregs[m_ptr];
      return b;
    end
    if (m_err) return 8'hFF;
    if (m_rd) begin
      m_ptr = (m_ptr + INC) % 16;
      return mregs[m_ptr];
    end
    mregs[m_ptr] = b;
    wr_q.push_back({4'(m_ptr), b});
    m_ptr = (m_ptr + INC) % 16;
    return b;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic [7:0] exp_tx);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    tx_q.push_back(exp_tx);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Send fb[] as one frame; optionally land the last byte on the ss rising cycle
  task automatic run_frame(input bit last_at_rise);
    logic [7:0] e;
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < fb.size(); i++) begin
      e = model_byte(i == 0, fb[i]);
      if (last_at_rise && i == fb.size() - 1) begin
        @(negedge clk);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        rx_byte  = fb[i];
        rx_valid = 1'b1;
        tx_q.push_back(8'hA5);
        @(negedge clk);
        rx_valid = 1'b0;
      end else begin
        drive_byte(fb[i], e);
      end
    end
    if (!last_at_rise) begin
      @(negedge clk);
      ss = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("tx_idle", 32'(tx_byte), 32'hA5);
  endtask

  task automatic loc_sweep();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      loc_addr = 4'(a);
      loc_req  = 1'b1;
      loc_q.push_back(mregs[a]);
    end
    @(negedge clk);
    loc_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int nd;
    for (int a = 0; a < 16; a++) mregs[a] = 8'h00;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_byte), 32'hA5);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a);
      @(negedge clk);
      chk("rst_loc_rdata", 32'(loc_rdata), 32'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames
    fb = '{8'h03, 8'h11, 8'h22}; run_frame(1'b0);
    fb = '{8'h83, 8'h00, 8'h00}; run_frame(1'b0);
    fb = '{8'h0F, 8'hAA, 8'hBB}; run_frame(1'b0);
    fb = '{8'h30, 8'h55, 8'h66}; run_frame(1'b0);
    fb = '{8'hF2, 8'h01};        run_frame(1'b0);
    loc_sweep();

    // Byte arriving while idle is ignored
    drive_byte(8'h77, 8'hA5);
    // Final write byte coinciding with frame end
    fb = '{8'h05, 8'hC3, 8'h3C}; run_frame(1'b1);
    fb = '{8'h85, 8'h00, 8'h00}; run_frame(1'b0);
    loc_sweep();

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:4] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cmd[3:0] = 4'($urandom_range(0, 15));
      fb = '{cmd};
      nd = $urandom_range(0, 4);
      for (int k = 0; k < nd; k++) fb.push_back(8'($urandom));
      run_frame((f % 9) == 4);
      if ((f % 15) == 14) loc_sweep();
    end

    // Reset in the middle of a write burst
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    drive_byte(8'h06, model_byte(1'b1, 8'h06));
    drive_byte(8'h9C, model_byte(1'b0, 8'h9C));
    reset = 1'b1;
    for (int a = 0; a < 16; a++) mregs[a] = 8'h00;
    repeat (2) @(negedge clk);
    chk("midrst_tx", 32'(tx_byte), 32'hA5);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_strobe", 32'(wr_strobe), 32'd0);
    ss = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    loc_sweep();
    fb = '{8'h86, 8'h00}; run_frame(1'b0);
    fb = '{8'h0A, 8'h5A}; run_frame(1'b0);
    loc_sweep();

    repeat (4) @(negedge clk);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("loc_q_drained", 32'(loc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
